// File: rtl/cobra_kb_pkg.sv
// Shared scan-code constants, key indices and set-2 scan-code to key-index lookup.
package cobra_kb_pkg;

    localparam int unsigned KC_W = 40;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BAT_OK = 8'hAA;

    // Key index = column + 5*row, matching the 74S412 buffer model.
    localparam logic [5:0] KEY_R0C0 = 6'd0,  KEY_R0C1 = 6'd1,  KEY_R0C2 = 6'd2,  KEY_R0C3 = 6'd3,  KEY_R0C4 = 6'd4;
    localparam logic [5:0] KEY_R1C0 = 6'd5,  KEY_R1C1 = 6'd6,  KEY_R1C2 = 6'd7,  KEY_R1C3 = 6'd8,  KEY_R1C4 = 6'd9;
    localparam logic [5:0] KEY_R2C0 = 6'd10, KEY_R2C1 = 6'd11, KEY_R2C2 = 6'd12, KEY_R2C3 = 6'd13, KEY_R2C4 = 6'd14;
    localparam logic [5:0] KEY_R3C0 = 6'd15, KEY_R3C1 = 6'd16, KEY_R3C2 = 6'd17, KEY_R3C3 = 6'd18, KEY_R3C4 = 6'd19;
    localparam logic [5:0] KEY_R4C0 = 6'd20, KEY_R4C1 = 6'd21, KEY_R4C2 = 6'd22, KEY_R4C3 = 6'd23, KEY_R4C4 = 6'd24;
    localparam logic [5:0] KEY_R5C0 = 6'd25, KEY_R5C1 = 6'd26, KEY_R5C2 = 6'd27, KEY_R5C3 = 6'd28, KEY_R5C4 = 6'd29;
    localparam logic [5:0] KEY_R6C0 = 6'd30, KEY_R6C1 = 6'd31, KEY_R6C2 = 6'd32, KEY_R6C3 = 6'd33, KEY_R6C4 = 6'd34;
    localparam logic [5:0] KEY_R7C0 = 6'd35, KEY_R7C1 = 6'd36, KEY_R7C2 = 6'd37, KEY_R7C3 = 6'd38, KEY_R7C4 = 6'd39;

    typedef enum logic [1:0] {
        RX_IDLE = 2'd0,
        RX_RECV = 2'd1,
        RX_DONE = 2'd2
    } rx_state_t;

    // Returns {hit, idx}; hit=0 for any code that has no key in the matrix.
    function automatic logic [6:0] sc2idx(input logic [7:0] code, input logic ext);
        logic [6:0] r;
        r = '0;
        if (ext) begin
            if (code == 8'h5A) r = {1'b1, KEY_R5C0};
        end else begin
            case (code)
                8'h16: r = {1'b1, KEY_R0C0};  8'h1E: r = {1'b1, KEY_R0C1};  8'h26: r = {1'b1, KEY_R0C2};
                8'h25: r = {1'b1, KEY_R0C3};  8'h2E: r = {1'b1, KEY_R0C4};
                8'h15: r = {1'b1, KEY_R1C0};  8'h1D: r = {1'b1, KEY_R1C1};  8'h24: r = {1'b1, KEY_R1C2};
                8'h2D: r = {1'b1, KEY_R1C3};  8'h2C: r = {1'b1, KEY_R1C4};
                8'h1C: r = {1'b1, KEY_R2C0};  8'h1B: r = {1'b1, KEY_R2C1};  8'h23: r = {1'b1, KEY_R2C2};
                8'h2B: r = {1'b1, KEY_R2C3};  8'h34: r = {1'b1, KEY_R2C4};
                8'h12: r = {1'b1, KEY_R3C0};  8'h59: r = {1'b1, KEY_R3C0};  8'h1A: r = {1'b1, KEY_R3C1};
                8'h22: r = {1'b1, KEY_R3C2};  8'h21: r = {1'b1, KEY_R3C3};  8'h2A: r = {1'b1, KEY_R3C4};
                8'h29: r = {1'b1, KEY_R4C0};  8'h41: r = {1'b1, KEY_R4C1};  8'h3A: r = {1'b1, KEY_R4C2};
                8'h31: r = {1'b1, KEY_R4C3};  8'h32: r = {1'b1, KEY_R4C4};
                8'h5A: r = {1'b1, KEY_R5C0};  8'h4B: r = {1'b1, KEY_R5C1};  8'h42: r = {1'b1, KEY_R5C2};
                8'h3B: r = {1'b1, KEY_R5C3};  8'h33: r = {1'b1, KEY_R5C4};
                8'h4D: r = {1'b1, KEY_R6C0};  8'h44: r = {1'b1, KEY_R6C1};  8'h43: r = {1'b1, KEY_R6C2};
                8'h3C: r = {1'b1, KEY_R6C3};  8'h35: r = {1'b1, KEY_R6C4};
                8'h45: r = {1'b1, KEY_R7C0};  8'h46: r = {1'b1, KEY_R7C1};  8'h3E: r = {1'b1, KEY_R7C2};
                8'h3D: r = {1'b1, KEY_R7C3};  8'h36: r = {1'b1, KEY_R7C4};
                default: r = '0;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_keycaps_if.sv
// PS/2 pad lines in, pressed-key vector and frame error out.
interface ps2_keycaps_if;
    import cobra_kb_pkg::*;

    logic            ps2_clk;
    logic            ps2_data;
    logic [KC_W-1:0] keycaps;
    logic            frame_err;

    modport master (output ps2_clk, output ps2_data, input keycaps, input frame_err);
    modport slave  (input ps2_clk, input ps2_data, output keycaps, output frame_err);
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pad synchronizers, falling-edge detect, 11-bit frame FSM, mid-frame timeout.
module ps2_rx
    import cobra_kb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic            r_clk_meta, r_clk_sync, r_clk_prev;
    logic            r_dat_meta, r_dat_sync;
    rx_state_t       r_state, w_state_nxt;
    logic [3:0]      r_bitcnt, w_bitcnt_nxt;
    logic [10:0]     r_shift, w_shift_nxt;
    logic [TW-1:0]   r_tmo, w_tmo_nxt;
    logic            r_byte_valid, w_valid_nxt;
    logic [7:0]      r_byte, w_byte_nxt;
    logic            r_frame_err, w_err_nxt;
    logic            w_fall;
    logic [10:0]     w_frame;
    logic            w_frame_ok;

    // Two-flop synchronizers; clock idles high so reset to 1 to avoid a false edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= i_ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= i_ps2_data;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_sync;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= RX_IDLE;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_tmo        <= '0;
            r_byte_valid <= 1'b0;
            r_byte       <= '0;
            r_frame_err  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bitcnt     <= w_bitcnt_nxt;
            r_shift      <= w_shift_nxt;
            r_tmo        <= w_tmo_nxt;
            r_byte_valid <= w_valid_nxt;
            r_byte       <= w_byte_nxt;
            r_frame_err  <= w_err_nxt;
        end
    end

    // Next state: bits shift in from the top so the start bit lands in [0] after 11 edges.
    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_tmo_nxt    = '0;
        w_valid_nxt  = 1'b0;
        w_byte_nxt   = r_byte;
        w_err_nxt    = 1'b0;
        w_frame      = {r_dat_sync, r_shift[10:1]};
        w_frame_ok   = ~w_frame[0] & (^w_frame[9:1]) & w_frame[10];
        case (r_state)
            RX_IDLE: begin
                if (w_fall) begin
                    w_shift_nxt  = w_frame;
                    w_bitcnt_nxt = 4'd1;
                    w_state_nxt  = RX_RECV;
                end
            end
            RX_RECV: begin
                if (w_fall) begin
                    w_shift_nxt = w_frame;
                    if (r_bitcnt == 4'd10) begin
                        w_state_nxt = RX_DONE;
                        w_valid_nxt = w_frame_ok;
                        w_err_nxt   = ~w_frame_ok;
                        w_byte_nxt  = w_frame[8:1];
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                    end
                end else if (r_tmo == TW'(TIMEOUT_CYCLES)) begin
                    w_state_nxt = RX_IDLE;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            RX_DONE: w_state_nxt = RX_IDLE;
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte       = r_byte;
    assign o_frame_err  = r_frame_err;
endmodule

// File: rtl/ps2_keycaps.sv
// PS/2 keyboard front-end: decodes set-2 make/break bytes into the Cobra1 pressed-key vector.
module ps2_keycaps
    import cobra_kb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic         clk,
    input  logic         rst_n,
    ps2_keycaps_if.slave kb
);
    logic            w_byte_valid;
    logic [7:0]      w_byte;
    logic            w_frame_err;
    logic [6:0]      w_map;
    logic [KC_W-1:0] w_mask;
    logic            r_brk, r_ext;
    logic [KC_W-1:0] r_keycaps;

    ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ps2_clk    (kb.ps2_clk),
        .i_ps2_data   (kb.ps2_data),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_frame_err  (w_frame_err)
    );

    assign w_map  = sc2idx(w_byte, r_ext);
    assign w_mask = KC_W'(1) << w_map[5:0];

    // Prefix flags and key vector; any non-prefix byte or error ends a prefix sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_brk     <= 1'b0;
            r_ext     <= 1'b0;
            r_keycaps <= '0;
        end else if (w_frame_err) begin
            r_brk <= 1'b0;
            r_ext <= 1'b0;
        end else if (w_byte_valid) begin
            if (w_byte == SC_BREAK) begin
                r_brk <= 1'b1;
            end else if (w_byte == SC_EXT) begin
                r_ext <= 1'b1;
            end else begin
                r_brk <= 1'b0;
                r_ext <= 1'b0;
                if (w_byte == SC_BAT_OK && !r_brk) begin
                    r_keycaps <= '0;
                end else if (w_map[6]) begin
                    r_keycaps <= r_brk ? (r_keycaps & ~w_mask) : (r_keycaps | w_mask);
                end
            end
        end
    end

    assign kb.keycaps   = r_keycaps;
    assign kb.frame_err = w_frame_err;
endmodule
